fetch_queue: RTL
================

# fetch_queue

Instruction-fetch front end that consumes the program counter and turns it into instruction-memory requests. It sits between the PC register and the IF/ID stage: it issues one request per accepted PC, stalls the PC when it cannot issue, and buffers in-order memory responses together with their PCs. It hands {pc, instruction} pairs to decode over a valid/ready handshake and discards in-flight work on a redirect flush.

## Interface
- DEPTH, 4: queue entries and maximum requests in flight; power of two, ≥2.
- RESET_INSTR, 32'h0000_0013: value driven on id_instr when the queue is empty (RISC-V NOP).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pc  in  32  current fetch PC from the PC register.
- pc_stall  out  1  1 = PC must hold this cycle (request not accepted).
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  equals pc.
- imem_rsp_valid  in  1  response beat; always accepted, strictly in request order.
- imem_rsp_data  in  32  instruction word.
- flush  in  1  redirect; kill queued and outstanding fetches.
- id_valid  out  1  head entry holds a returned instruction.
- id_ready  in  1  decode consumes the head entry.
- id_pc  out  32  PC of the head entry.
- id_instr  out  32  instruction of the head entry.

## Operation
- State: circular entry array {pc, instr, filled}; pointers alloc_ptr, fill_ptr, head_ptr (log2(DEPTH) bits, wrap modulo DEPTH); occupancy count (0..DEPTH); drop_cnt (0..DEPTH).
- imem_req_valid = !flush && (occupancy + drop_cnt < DEPTH). imem_req_addr = pc.
- Issue occurs when imem_req_valid && imem_req_ready. The entry at alloc_ptr gets {pc, filled=0}, and alloc_ptr increments.
- pc_stall = !flush && !issue. During flush the PC is free to load the redirect target.
- Response: if drop_cnt > 0, discard the beat and decrement drop_cnt. Otherwise write instr at fill_ptr, set filled=1, and increment fill_ptr.
- id_valid = !flush && entry[head_ptr].filled && occupancy > 0. A pop occurs on id_valid && id_ready; it clears filled and increments head_ptr.
- id_pc and id_instr come from the head entry when id_valid is 1. When id_valid is 0 they read 0 and RESET_INSTR.
- Flush: set drop_cnt to drop_cnt + (allocated but unfilled entries). A response arriving in the flush cycle is treated as old: it is discarded and netted against the new drop_cnt. Occupancy goes to 0, all pointers reset to 0, and all filled bits clear. No issue and no pop occur in the flush cycle.
- Issue, response and pop may all happen in the same cycle; occupancy changes by issue − pop.
- A response with nothing outstanding is a protocol error. It is ignored and flagged by an assertion in simulation.

## Timing
- Reset (asserted low, asynchronous) clears all pointers, counters and filled bits. While reset is asserted: imem_req_valid=0, pc_stall=0, id_valid=0, id_pc=0, id_instr=RESET_INSTR.
- Latency: a response in cycle N makes id_valid=1 in cycle N+1. There is no combinational rsp→id bypass.
- Issue is combinational on imem_req_ready. The address is stable while imem_req_valid is high.
- Full: occupancy + drop_cnt = DEPTH, so imem_req_valid=0 and pc_stall=1 until a pop or a dropped response frees a slot. The slot is usable in the following cycle.
- Empty: id_valid=0. Back-to-back throughput is 1 instruction per cycle when memory responds every cycle.
- If reset is asserted mid-operation, any later responses for pre-reset requests are the memory's responsibility; the block does not track them.

## Structure
- Shared package fetch_pkg holds the DEPTH default, the RESET_INSTR/NOP constant, and the typedef for an entry struct {pc[31:0], instr[31:0], filled}.
- Sub-module fetch_entry_ram is the DEPTH-entry storage array. It has one allocate write port (pc), one fill write port (instr), one async head read, and a clear. The control logic (pointers, counters, flush accounting) stays in fetch_queue.

## Test plan
- Reset then steady flow: imem_req_ready=1 and 1-cycle memory with pc stepping 0,4,8. Expect id_pc 0,4,8 with their instrs, one per cycle from cycle 2; pc_stall stays 0.
- Backpressure: id_ready=0 with DEPTH=4. After 4 issues, imem_req_valid=0 and pc_stall=1. Raising id_ready pops pc=0 first, and a new issue follows one cycle later.
- Memory stall: imem_req_ready=0 for 3 cycles. Expect pc_stall=1 for those 3 cycles, the address held at 0x10, then issue at 0x10.
- Flush with 2 outstanding: flush=1 in one cycle, redirect pc=0x100. The next 2 responses are dropped, and the first id_valid shows id_pc=0x100.
- Flush in the same cycle as a response, with 3 outstanding. Expect drop_cnt=2 afterward and no stale id_valid.
- Asynchronous reset mid-stream with a full queue. Outputs return to their reset values immediately. After release, fetch restarts cleanly from pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch queue:
//   FQ_DEPTH       default number of queue entries / requests in flight
//   NOP_INSTR      instruction presented to decode when nothing is valid
//   fetch_entry_t  one queue slot: {pc, instr, filled}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          FQ_DEPTH  = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // RISC-V addi x0,x0,0

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_ram.sv
// -----------------------------------------------------------------------------
// fetch_entry_ram
// DEPTH-entry storage for the fetch queue.
// Ports:
//   clk, reset      clock, asynchronous active-low reset (clears filled bits)
//   alloc_en/idx/pc allocate write: store pc, mark entry unfilled
//   fill_en/idx/instr fill write: store instruction, mark entry filled
//   pop_en/idx      retire entry: mark unfilled
//   clear           mark every entry unfilled (redirect flush)
//   head_idx        asynchronous read address
//   head_entry      {pc, instr, filled} of the entry at head_idx
// The pc/instr arrays carry no reset; only the filled flags matter for
// correctness, so only they are reset.
// -----------------------------------------------------------------------------
module fetch_entry_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_en,
    input  logic [AW-1:0]      alloc_idx,
    input  logic [31:0]        alloc_pc,
    input  logic               fill_en,
    input  logic [AW-1:0]      fill_idx,
    input  logic [31:0]        fill_instr,
    input  logic               pop_en,
    input  logic [AW-1:0]      pop_idx,
    input  logic               clear,
    input  logic [AW-1:0]      head_idx,
    output fetch_entry_t       head_entry
);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [DEPTH-1:0] filled_vec;

    always_ff @(posedge clk) begin
        if (alloc_en) begin
            pc_mem[alloc_idx] <= alloc_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            instr_mem[fill_idx] <= fill_instr;
        end
    end

    // One flag register per slot. The control logic guarantees that a fill
    // never targets the slot being popped or allocated in the same cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
            localparam logic [AW-1:0] SLOT = AW'(gi);
            logic filled_bit_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    filled_bit_reg <= 1'b0;
                end else if (clear) begin
                    filled_bit_reg <= 1'b0;
                end else if (fill_en && (fill_idx == SLOT)) begin
                    filled_bit_reg <= 1'b1;
                end else if ((pop_en && (pop_idx == SLOT)) ||
                             (alloc_en && (alloc_idx == SLOT))) begin
                    filled_bit_reg <= 1'b0;
                end
            end

            assign filled_vec[gi] = filled_bit_reg;
        end
    endgenerate

    assign head_entry.pc     = pc_mem[head_idx];
    assign head_entry.instr  = instr_mem[head_idx];
    assign head_entry.filled = filled_vec[head_idx];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end: turns the PC into in-order instruction-memory
// requests, buffers the responses with their PCs and hands {pc, instr} to
// decode over valid/ready. A flush kills queued and outstanding work.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   pc                         current fetch PC
//   pc_stall                   PC must hold (request not accepted this cycle)
//   imem_req_valid/ready/addr  request channel to instruction memory
//   imem_rsp_valid/data        in-order response beats (always accepted)
//   flush                      redirect; drop everything in flight
//   id_valid/ready/pc/instr    head entry handshake towards decode
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH       = FQ_DEPTH,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;                 // counts range 0..DEPTH

    logic [AW-1:0] alloc_ptr_reg, alloc_ptr_next;
    logic [AW-1:0] fill_ptr_reg,  fill_ptr_next;
    logic [AW-1:0] head_ptr_reg,  head_ptr_next;
    logic [CW-1:0] occ_reg,  occ_next;          // live entries (pending + filled)
    logic [CW-1:0] pend_reg, pend_next;         // live entries awaiting a response
    logic [CW-1:0] drop_reg, drop_next;         // responses still owed to killed requests

    logic          req_ok;
    logic          issue;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          rsp_owned;
    logic          head_valid;
    logic          pop;
    logic [CW:0]   budget_used;
    fetch_entry_t  head_entry;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Killed-but-outstanding requests still occupy memory slots, so they
    // count against the in-flight budget alongside live entries.
    assign budget_used = {1'b0, occ_reg} + {1'b0, drop_reg};
    assign req_ok      = reset && !flush && (budget_used < (CW+1)'(DEPTH));
    assign issue       = req_ok && imem_req_ready;

    // A beat belongs to an old request while drop_reg is non-zero.
    assign rsp_owned   = (drop_reg != '0) || (pend_reg != '0);
    assign rsp_drop    = imem_rsp_valid && (drop_reg != '0);
    assign rsp_fill    = imem_rsp_valid && (drop_reg == '0) && (pend_reg != '0) && !flush;

    assign head_valid  = reset && !flush && head_entry.filled && (occ_reg != '0);
    assign pop         = head_valid && id_ready;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        alloc_ptr_next = alloc_ptr_reg;
        fill_ptr_next  = fill_ptr_reg;
        head_ptr_next  = head_ptr_reg;
        occ_next       = occ_reg;
        pend_next      = pend_reg;
        drop_next      = drop_reg;

        if (flush) begin
            alloc_ptr_next = '0;
            fill_ptr_next  = '0;
            head_ptr_next  = '0;
            occ_next       = '0;
            pend_next      = '0;
            // Every pending live request becomes a drop; a beat landing in
            // this same cycle retires one of the (old) outstanding requests.
            drop_next      = drop_reg + pend_reg - CW'(imem_rsp_valid && rsp_owned);
        end else begin
            alloc_ptr_next = alloc_ptr_reg + AW'(issue);
            fill_ptr_next  = fill_ptr_reg + AW'(rsp_fill);
            head_ptr_next  = head_ptr_reg + AW'(pop);
            occ_next       = occ_reg + CW'(issue) - CW'(pop);
            pend_next      = pend_reg + CW'(issue) - CW'(rsp_fill);
            drop_next      = drop_reg - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            head_ptr_reg  <= '0;
            occ_reg       <= '0;
            pend_reg      <= '0;
            drop_reg      <= '0;
        end else begin
            alloc_ptr_reg <= alloc_ptr_next;
            fill_ptr_reg  <= fill_ptr_next;
            head_ptr_reg  <= head_ptr_next;
            occ_reg       <= occ_next;
            pend_reg      <= pend_next;
            drop_reg      <= drop_next;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    fetch_entry_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_entry_ram (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (issue),
        .alloc_idx  (alloc_ptr_reg),
        .alloc_pc   (pc),
        .fill_en    (rsp_fill),
        .fill_idx   (fill_ptr_reg),
        .fill_instr (imem_rsp_data),
        .pop_en     (pop),
        .pop_idx    (head_ptr_reg),
        .clear      (flush),
        .head_idx   (head_ptr_reg),
        .head_entry (head_entry)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid = req_ok;
    assign imem_req_addr  = pc;
    assign pc_stall       = reset && !flush && !issue;
    assign id_valid       = head_valid;
    assign id_pc          = head_valid ? head_entry.pc    : 32'h0;
    assign id_instr       = head_valid ? head_entry.instr : RESET_INSTR;

`ifndef SYNTHESIS
    // A response with no outstanding request is a memory protocol error;
    // the beat is ignored by the datapath.
    rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> rsp_owned);
`endif

endmodule
